regfile_write_port: RTL and testbench
=====================================

REGFILE_WRITE_PORT -- requirements
Module: regfile_write_port

Interface
REQ-001 Parameter ZERO_REG, default 31: index of the hardwired-zero register (X31/XZR); writes to it are discarded.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 wr_valid  input  1  write request valid.
REQ-005 wr_ready  output  1  write port can accept; handshake when wr_valid && wr_ready at a rising edge.
REQ-006 wr_addr  input  5  destination register index 0..31.
REQ-007 wr_data  input  32  write data.
REQ-008 clr_req  input  1  request a sequential clear of the whole register file.
REQ-009 busy  output  1  high while the clear sequence runs.
REQ-010 regs_flat  output  1024  all register contents; register i on bits [32i+31:32i], feeds the 32:1 read multiplexers.
REQ-011 wr_count  output  16  count of accepted write handshakes.

Function
REQ-012 Storage SHALL be 32 registers x 32 bits; the write address SHALL be fully decoded 5-to-32 (one-hot enable), exactly one register enabled per accepted write.
REQ-013 FSM SHALL have two states: IDLE and CLEAR.
REQ-014 wr_ready SHALL equal (state == IDLE), combinational from state only, never from wr_valid.
REQ-015 busy SHALL equal (state == CLEAR).
REQ-016 Accepted write SHALL update register wr_addr at the handshake edge; regs_flat SHALL show the new value in the following cycle (1-cycle write latency, no combinational bypass).
REQ-017 Write to ZERO_REG SHALL complete the handshake and increment wr_count but leave register ZERO_REG at 0.
REQ-018 Register ZERO_REG SHALL read 0 on regs_flat at all times.
REQ-019 IDLE -> CLEAR when clr_req = 1 at an edge in IDLE; 5-bit clear index SHALL load 0 on entry.
REQ-020 In CLEAR, one register (index = clear index) SHALL be zeroed per cycle, index incrementing by 1; after index 31 is zeroed the FSM SHALL return to IDLE; clear takes exactly 32 cycles with busy high.
REQ-021 clr_req SHALL be ignored while in CLEAR (no restart, no queuing).
REQ-022 wr_valid in CLEAR SHALL not be accepted; requester holds wr_addr/wr_data until wr_ready.
REQ-023 Simultaneous wr_valid and clr_req in IDLE: the write SHALL be accepted that edge and the FSM enters CLEAR; the written register is subsequently zeroed by the sweep.
REQ-024 wr_count SHALL increment by 1 per accepted handshake, saturate at 16'hFFFF, and be unaffected by the clear sequence.

Reset
REQ-025 reset SHALL take priority over every other input in the same edge, including handshakes and clr_req.
REQ-026 After a reset edge: all 32 registers = 0, state = IDLE, clear index = 0, wr_count = 0, hence busy = 0, wr_ready = 1.
REQ-027 reset asserted during CLEAR SHALL abort the sweep and apply REQ-026 at that edge.
REQ-028 A write presented during a reset edge SHALL not be stored or counted.

Verification
REQ-029 Reset, then write 32'hDEADBEEF to reg 5 -> regs_flat[191:160] = 32'hDEADBEEF next cycle, wr_count = 1, all other registers 0.
REQ-030 Write 32'h12345678 to reg 31 -> handshake completes, wr_count increments, regs_flat[1023:992] remains 0.
REQ-031 Fill regs 0..30 with i+1, pulse clr_req -> busy high exactly 32 cycles, wr_ready low throughout, all registers 0 at end, wr_count unchanged.
REQ-032 wr_valid (reg 3, 32'hA5A5A5A5) and clr_req same IDLE edge -> write accepted (wr_count+1), reg 3 = 32'hA5A5A5A5 until sweep index 3 zeroes it in the 4th CLEAR cycle.
REQ-033 Hold wr_valid during CLEAR -> no acceptance until first IDLE cycle, then exactly one write; clr_req pulsed mid-sweep -> sweep still ends after 32 cycles.
REQ-034 Assert reset at CLEAR cycle 10 -> next cycle busy = 0, wr_ready = 1, wr_count = 0, all registers 0; force 65536 writes -> wr_count holds 16'hFFFF.

Source files
------------

// File: rtl/regfile_write_port.sv
// 32x32 register file write port with a hardwired-zero register and a sequential clear sweep.
// Latency: an accepted write is visible on regs_flat one cycle after the handshake edge; a clear takes 32 cycles.
// Backpressure: wr_ready drops for the whole clear sweep; the requester holds its write until wr_ready returns.
module regfile_write_port #(
    parameter int ZERO_REG = 31
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [4:0]    wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          clr_req,
    output logic          busy,
    output logic [1023:0] regs_flat,
    output logic [15:0]   wr_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  clr_idx;
    logic [31:0] regs [32];
    logic        wr_fire;
    logic [31:0] wr_en;
    logic [31:0] clr_en;

    // Ready depends on state only, so a held write never races the sweep.
    assign wr_ready = (state == IDLE);
    assign busy     = (state == CLEAR);
    assign wr_fire  = wr_valid && wr_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: start a sweep on clr_req in IDLE, leave after the last index is zeroed.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (clr_req) state_nxt = CLEAR;
            CLEAR:   if (clr_idx == 5'd31) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One-hot write and clear enables from the 5-bit write address and sweep index.
    always_comb begin
        wr_en  = '0;
        clr_en = '0;
        if (wr_fire) begin
            wr_en[wr_addr] = 1'b1;
        end
        if (state == CLEAR) begin
            clr_en[clr_idx] = 1'b1;
        end
    end

    // Sweep index: restart at 0 on entry, advance once per CLEAR cycle (wraps to 0 after 31).
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_idx <= '0;
        end else if (state == IDLE && clr_req) begin
            clr_idx <= '0;
        end else if (state == CLEAR) begin
            clr_idx <= clr_idx + 5'd1;
        end
    end

    // Register storage; the zero register never takes a value and writes cannot occur during a sweep.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 32; i++) begin
            if (reset) begin
                regs[i] <= '0;
            end else if (i == ZERO_REG) begin
                regs[i] <= '0;
            end else if (clr_en[i]) begin
                regs[i] <= '0;
            end else if (wr_en[i]) begin
                regs[i] <= wr_data;
            end
        end
    end

    // Saturating count of accepted handshakes, including those aimed at the zero register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_count <= '0;
        end else if (wr_fire && wr_count != 16'hFFFF) begin
            wr_count <= wr_count + 16'd1;
        end
    end

    // Flatten storage for the read muxes; the zero register slice is tied low.
    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < 32; i++) begin
            regs_flat[32*i +: 32] = (i == ZERO_REG) ? 32'd0 : regs[i];
        end
    end

endmodule

// File: tb/tb_regfile_write_port.sv
// Bench for regfile_write_port: table-driven writes, clear sweep, write/clear collision, reset abort, count saturation.
// Inputs change 1ns after each rising edge, outputs are sampled there too.
// A behavioural model plus a write scoreboard supply every expected value.
module tb_regfile_write_port;

    localparam int ZR = 31;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_valid;
    logic          wr_ready;
    logic [4:0]    wr_addr;
    logic [31:0]   wr_data;
    logic          clr_req;
    logic          busy;
    logic [1023:0] regs_flat;
    logic [15:0]   wr_count;

    regfile_write_port #(.ZERO_REG(ZR)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .clr_req   (clr_req),
        .busy      (busy),
        .regs_flat (regs_flat),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [15:0] cnt;
    } sb_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    sb_t         sbq[$];
    vec_t        vecs[6];
    logic [31:0] m_regs [32];
    logic        m_busy;
    logic [4:0]  m_idx;
    logic [15:0] m_cnt;
    int          total = 0;
    int          bad   = 0;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? 16'hFFFF : v + 16'd1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] reg_of(input int i);
        return regs_flat[32*i +: 32];
    endfunction

    task automatic check_all(input string tag);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("%s reg%0d", tag, i), reg_of(i), m_regs[i]);
        end
        chk({tag, " count"}, {16'd0, wr_count}, {16'd0, m_cnt});
        chk({tag, " busy"}, {31'd0, busy}, {31'd0, m_busy});
        chk({tag, " ready"}, {31'd0, wr_ready}, {31'd0, !m_busy});
    endtask

    // One clock: check handshake outputs, drive inputs, advance model, settle scoreboard.
    task automatic step(input logic v, input logic [4:0] a, input logic [31:0] d,
                        input logic c, input logic r);
        logic fire;
        sb_t  e;
        chk("ready", {31'd0, wr_ready}, {31'd0, !m_busy});
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        wr_valid = v;
        wr_addr  = a;
        wr_data  = d;
        clr_req  = c;
        reset    = r;
        fire = v && !m_busy && !r;
        if (fire) begin
            e.addr = a;
            e.data = (int'(a) == ZR) ? 32'd0 : d;
            e.cnt  = sat_inc(m_cnt);
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        if (r) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_busy = 1'b0;
            m_idx  = '0;
            m_cnt  = '0;
        end else begin
            if (fire) begin
                if (int'(a) != ZR) m_regs[a] = d;
                m_cnt = sat_inc(m_cnt);
            end
            if (m_busy) begin
                m_regs[m_idx] = '0;
                if (m_idx == 5'd31) m_busy = 1'b0;
                m_idx = m_idx + 5'd1;
            end else if (c) begin
                m_busy = 1'b1;
                m_idx  = '0;
            end
        end
        if (fire) begin
            e = sbq.pop_front();
            chk($sformatf("sb reg%0d", e.addr), reg_of(int'(e.addr)), e.data);
            chk("sb count", {16'd0, wr_count}, {16'd0, e.cnt});
        end
    endtask

    task automatic idle_step();
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          busy_cycles;
        logic [15:0] cnt0;

        vecs[0] = '{addr: 5'd5,  data: 32'hDEADBEEF, exp: 32'hDEADBEEF};
        vecs[1] = '{addr: 5'd31, data: 32'h12345678, exp: 32'h00000000};
        vecs[2] = '{addr: 5'd0,  data: 32'h00000001, exp: 32'h00000001};
        vecs[3] = '{addr: 5'd30, data: 32'hFFFFFFFF, exp: 32'hFFFFFFFF};
        vecs[4] = '{addr: 5'd5,  data: 32'h11111111, exp: 32'h11111111};
        vecs[5] = '{addr: 5'd17, data: 32'hA5A55A5A, exp: 32'hA5A55A5A};

        // Power-up reset, DUT state unknown before it.
        wr_valid = 1'b1;
        wr_addr  = 5'd4;
        wr_data  = 32'h0BAD0BAD;
        clr_req  = 1'b1;
        reset    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_busy = 1'b0;
        m_idx  = '0;
        m_cnt  = '0;
        idle_step();
        check_all("reset");

        // Table-driven writes, first entry is the DEADBEEF/reg5 case.
        for (int k = 0; k < 6; k++) begin
            step(1'b1, vecs[k].addr, vecs[k].data, 1'b0, 1'b0);
            chk($sformatf("vec%0d data", k), reg_of(int'(vecs[k].addr)), vecs[k].exp);
            chk($sformatf("vec%0d count", k), {16'd0, wr_count}, k + 1);
            if (k == 0) begin
                check_all("first write");
            end
        end
        chk("zero reg slice", regs_flat[1023:992], 32'd0);

        // Fill 0..30 with i+1 then sweep.
        for (int i = 0; i < 31; i++) begin
            step(1'b1, 5'(i), 32'(i + 1), 1'b0, 1'b0);
        end
        check_all("filled");
        cnt0 = wr_count;
        step(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        busy_cycles = 0;
        n = 0;
        while (busy && n < 40) begin
            busy_cycles++;
            chk("ready low in clear", {31'd0, wr_ready}, 32'd0);
            idle_step();
            n++;
        end
        chk("clear busy cycles", busy_cycles, 32);
        chk("count after clear", {16'd0, wr_count}, {16'd0, cnt0});
        check_all("after clear");

        // Refill a few registers, then write reg3 and clr_req on the same IDLE edge.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 1'b0);
        end
        cnt0 = wr_count;
        step(1'b1, 5'd3, 32'hA5A5A5A5, 1'b1, 1'b0);
        chk("collide count", {16'd0, wr_count}, {16'd0, cnt0 + 16'd1});
        chk("collide busy", {31'd0, busy}, 32'd1);
        busy_cycles = 1;
        for (int k = 0; k < 3; k++) begin
            idle_step();
            if (busy) busy_cycles++;
            chk($sformatf("reg3 held sweep%0d", k), reg_of(3), 32'hA5A5A5A5);
        end
        idle_step();
        if (busy) busy_cycles++;
        chk("reg3 zeroed 4th", reg_of(3), 32'd0);
        chk("reg4 not yet", reg_of(4), 32'h104);

        // Hold a write through the remaining sweep, pulse clr_req mid-sweep.
        cnt0 = wr_count;
        n = 0;
        while (busy && n < 40) begin
            step(1'b1, 5'd7, 32'hCAFEF00D, (n == 10), 1'b0);
            if (busy) busy_cycles++;
            n++;
        end
        chk("collide busy cycles", busy_cycles, 32);
        chk("no accept in clear", {16'd0, wr_count}, {16'd0, cnt0});
        step(1'b1, 5'd7, 32'hCAFEF00D, 1'b0, 1'b0);
        idle_step();
        chk("held write once", {16'd0, wr_count}, {16'd0, cnt0 + 16'd1});
        chk("held write reg7", reg_of(7), 32'hCAFEF00D);
        check_all("after held");

        // Reset during CLEAR cycle 10, with a write and clr_req also presented.
        step(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        for (int k = 0; k < 9; k++) idle_step();
        chk("busy at cycle 10", {31'd0, busy}, 32'd1);
        step(1'b1, 5'd12, 32'h77777777, 1'b1, 1'b1);
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort ready", {31'd0, wr_ready}, 32'd1);
        chk("abort count", {16'd0, wr_count}, 32'd0);
        check_all("abort");

        // Write during a reset edge in IDLE is neither stored nor counted.
        step(1'b1, 5'd9, 32'h99999999, 1'b0, 1'b0);
        step(1'b1, 5'd9, 32'h55555555, 1'b0, 1'b1);
        chk("reset write reg9", reg_of(9), 32'd0);
        chk("reset write count", {16'd0, wr_count}, 32'd0);

        // Saturation: 65536 writes from zero.
        for (int k = 0; k < 65534; k++) begin
            step(1'b1, k[4:0], k, 1'b0, 1'b0);
        end
        chk("count fffe", {16'd0, wr_count}, 32'h0000FFFE);
        step(1'b1, 5'd1, 32'h1, 1'b0, 1'b0);
        chk("count ffff", {16'd0, wr_count}, 32'h0000FFFF);
        step(1'b1, 5'd2, 32'h2, 1'b0, 1'b0);
        chk("count sat", {16'd0, wr_count}, 32'h0000FFFF);
        idle_step();
        check_all("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
